// File: rtl/frame_addr_gen_pkg.sv
// Shared types and sizing helpers for the frame-buffer read address generator.
package frame_addr_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fag_state_t;

    localparam int FRAME_W_QQVGA = 160;
    localparam int FRAME_H_QQVGA = 120;

    function automatic int fag_addr_bits(input int banks, input int w, input int h);
        return $clog2(banks * w * h);
    endfunction

endpackage

// File: rtl/frame_addr_gen_if.sv
// Handshake between the VGA timing/enable logic (master) and the address generator (slave).
interface frame_addr_if #(
    parameter int ADDR_W = 17
);
    logic              enable;
    logic              vsync;
    logic              swap_req;
    logic [ADDR_W-1:0] address;
    logic              addr_valid;
    logic              bank_sel;
    logic              frame_done;

    modport master (
        output enable, vsync, swap_req,
        input  address, addr_valid, bank_sel, frame_done
    );

    modport slave (
        input  enable, vsync, swap_req,
        output address, addr_valid, bank_sel, frame_done
    );
endinterface

// File: rtl/frame_addr_gen_rep_counter.sv
// Modulo-N counter with synchronous clear; exposes next value and a wrap pulse for cascading.
module rep_counter #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk25,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         wrap
);

    always_comb begin
        count_nxt = count;
        wrap      = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (en) begin
            if (count == W'(N - 1)) begin
                count_nxt = '0;
                wrap      = 1'b1;
            end else begin
                count_nxt = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) count <= '0;
        else      count <= count_nxt;
    end

endmodule

// File: rtl/frame_addr_gen.sv
// Frame-buffer read address generator with pixel/line replication and ping-pong banks.
// state | meaning
// SYNC  | held at frame start, counters zero, address = bank base
// SCAN  | live pixels, address advances on enable
// DONE  | last pixel consumed, address holds until next vsync cycle
module frame_addr_gen
    import frame_addr_pkg::*;
#(
    parameter int H_PIX   = FRAME_W_QQVGA,
    parameter int V_LINES = FRAME_H_QQVGA,
    parameter int SCALE   = 1,
    parameter int BANKS   = 1,
    parameter int ADDR_W  = 17
) (
    input  logic          clk25,
    input  logic          rst,
    frame_addr_if.slave   bus
);

    if (!(SCALE == 1 || SCALE == 2 || SCALE == 4)) begin : g_bad_scale
        $error("frame_addr_gen: SCALE must be 1, 2 or 4");
    end
    if (!(BANKS == 1 || BANKS == 2)) begin : g_bad_banks
        $error("frame_addr_gen: BANKS must be 1 or 2");
    end
    if (ADDR_W < fag_addr_bits(BANKS, H_PIX, V_LINES)) begin : g_bad_addr_w
        $error("frame_addr_gen: ADDR_W too small for frame storage");
    end

    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int XW = $clog2(H_PIX);
    localparam int YW = $clog2(V_LINES);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(H_PIX * V_LINES);
    localparam logic [ADDR_W-1:0] LINE_STEP  = ADDR_W'(H_PIX);

    function automatic logic [ADDR_W-1:0] bank_base(input logic b);
        return b ? BANK1_BASE : '0;
    endfunction

    fag_state_t state, state_nxt;

    logic [SW-1:0]     xr_cnt, xr_nxt, yr_cnt, yr_nxt;
    logic [XW-1:0]     x_cnt, x_nxt;
    logic [YW-1:0]     y_cnt, y_nxt;
    logic              xr_wrap, x_wrap, yr_wrap, y_wrap;
    logic [ADDR_W-1:0] line_base, line_base_nxt;
    logic [ADDR_W-1:0] address_q, address_nxt;
    logic              addr_valid_q, frame_done_q;
    logic              bank_q, bank_nxt, swap_pend, pend_nxt;
    logic              vsync_prev, vsync_fall;
    logic              clr, at_last, advance, step, consume_last;
    logic              unused_nxt;

    assign clr          = !bus.vsync;
    assign vsync_fall   = vsync_prev && !bus.vsync;
    assign at_last      = (xr_cnt == SW'(SCALE - 1)) && (x_cnt == XW'(H_PIX - 1)) &&
                          (yr_cnt == SW'(SCALE - 1)) && (y_cnt == YW'(V_LINES - 1));
    assign advance      = (state == SCAN) && bus.vsync && bus.enable;
    // Counters freeze on the final pixel so DONE keeps pointing at it.
    assign step         = advance && !at_last;
    assign consume_last = advance && at_last;
    assign unused_nxt   = ^{xr_nxt, yr_nxt, y_nxt};

    rep_counter #(.N(SCALE))   u_xr (.clk25(clk25), .rst(rst), .clr(clr), .en(step),
                                     .count(xr_cnt), .count_nxt(xr_nxt), .wrap(xr_wrap));
    rep_counter #(.N(H_PIX))   u_x  (.clk25(clk25), .rst(rst), .clr(clr), .en(xr_wrap),
                                     .count(x_cnt), .count_nxt(x_nxt), .wrap(x_wrap));
    rep_counter #(.N(SCALE))   u_yr (.clk25(clk25), .rst(rst), .clr(clr), .en(x_wrap),
                                     .count(yr_cnt), .count_nxt(yr_nxt), .wrap(yr_wrap));
    rep_counter #(.N(V_LINES)) u_y  (.clk25(clk25), .rst(rst), .clr(clr), .en(yr_wrap),
                                     .count(y_cnt), .count_nxt(y_nxt), .wrap(y_wrap));

    always_comb begin
        line_base_nxt = line_base;
        if (clr)                     line_base_nxt = '0;
        else if (yr_wrap && !y_wrap) line_base_nxt = line_base + LINE_STEP;
    end

    // A request landing on the swap edge itself is kept for the following frame.
    always_comb begin
        bank_nxt = 1'b0;
        pend_nxt = 1'b0;
        if (BANKS == 2) begin
            bank_nxt = bank_q;
            pend_nxt = swap_pend || bus.swap_req;
            if (vsync_fall && swap_pend) begin
                bank_nxt = !bank_q;
                pend_nxt = bus.swap_req;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (!bus.vsync) begin
            state_nxt = SYNC;
        end else begin
            case (state)
                SYNC:    state_nxt = SCAN;
                SCAN:    if (consume_last) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_comb begin
        address_nxt = address_q;
        if (!bus.vsync)           address_nxt = bank_base(bank_nxt);
        else if (state == SYNC)   address_nxt = bank_base(bank_q);
        else if (step)            address_nxt = bank_base(bank_q) + line_base_nxt + ADDR_W'(x_nxt);
    end

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) state <= SYNC;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk25 or negedge rst) begin
        if (!rst) begin
            address_q    <= '0;
            addr_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            bank_q       <= 1'b0;
            swap_pend    <= 1'b0;
            vsync_prev   <= 1'b1;
            line_base    <= '0;
        end else begin
            address_q    <= address_nxt;
            addr_valid_q <= (state_nxt == SCAN);
            frame_done_q <= consume_last;
            bank_q       <= bank_nxt;
            swap_pend    <= pend_nxt;
            vsync_prev   <= bus.vsync;
            line_base    <= line_base_nxt;
        end
    end

    assign bus.address    = address_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.bank_sel   = bank_q;

endmodule

// File: tb/tb_frame_addr_gen.sv
// Directed bench for frame_addr_gen: 4x3 frame, dual-bank scale-1 instance and single-bank scale-2 instance.
module tb_frame_addr_gen;

    logic clk25 = 1'b0;
    logic rst   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk25 = ~clk25;

    frame_addr_if #(.ADDR_W(8)) bus_a ();
    frame_addr_if #(.ADDR_W(8)) bus_b ();

    frame_addr_gen #(.H_PIX(4), .V_LINES(3), .SCALE(1), .BANKS(2), .ADDR_W(8)) u_a (
        .clk25(clk25), .rst(rst), .bus(bus_a)
    );
    frame_addr_gen #(.H_PIX(4), .V_LINES(3), .SCALE(2), .BANKS(1), .ADDR_W(8)) u_b (
        .clk25(clk25), .rst(rst), .bus(bus_b)
    );

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (bus_a.address !== 8'd0 || bus_a.addr_valid !== 1'b0 ||
            bus_a.bank_sel !== 1'b0 || bus_a.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: addr=%0d valid=%b bank=%b done=%b, expected 0 0 0 0",
                     bus_a.address, bus_a.addr_valid, bus_a.bank_sel, bus_a.frame_done);
        end
        checks++;
        if (bus_b.address !== 8'd0 || bus_b.addr_valid !== 1'b0 ||
            bus_b.bank_sel !== 1'b0 || bus_b.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_b: addr=%0d valid=%b bank=%b done=%b, expected 0 0 0 0",
                     bus_b.address, bus_b.addr_valid, bus_b.bank_sel, bus_b.frame_done);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_linear();
        bus_a.vsync  = 1'b1;
        bus_a.enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (bus_a.address !== 8'(i) || bus_a.addr_valid !== 1'b1 || bus_a.frame_done !== 1'b0) begin
                failures++;
                $display("FAIL linear[%0d]: addr=%0d valid=%b done=%b, expected %0d 1 0",
                         i, bus_a.address, bus_a.addr_valid, bus_a.frame_done, i);
            end
        end
        step();
        checks++;
        if (bus_a.frame_done !== 1'b1 || bus_a.addr_valid !== 1'b0 || bus_a.address !== 8'd11) begin
            failures++;
            $display("FAIL linear_done: done=%b valid=%b addr=%0d, expected 1 0 11",
                     bus_a.frame_done, bus_a.addr_valid, bus_a.address);
        end
        step();
        checks++;
        if (bus_a.frame_done !== 1'b0 || bus_a.addr_valid !== 1'b0 || bus_a.address !== 8'd11) begin
            failures++;
            $display("FAIL linear_hold: done=%b valid=%b addr=%0d, expected 0 0 11",
                     bus_a.frame_done, bus_a.addr_valid, bus_a.address);
        end
        bus_a.vsync  = 1'b0;
        bus_a.enable = 1'b0;
        step();
    endtask

    task automatic test_scale2();
        int exp_addr;
        bus_b.vsync  = 1'b1;
        bus_b.enable = 1'b1;
        for (int n = 0; n < 48; n++) begin
            step();
            exp_addr = (n / 16) * 4 + (n / 2) % 4;
            checks++;
            if (bus_b.address !== 8'(exp_addr) || bus_b.addr_valid !== 1'b1 || bus_b.frame_done !== 1'b0) begin
                failures++;
                $display("FAIL scale2[%0d]: addr=%0d valid=%b done=%b, expected %0d 1 0",
                         n, bus_b.address, bus_b.addr_valid, bus_b.frame_done, exp_addr);
            end
        end
        step();
        checks++;
        if (bus_b.frame_done !== 1'b1 || bus_b.addr_valid !== 1'b0 || bus_b.address !== 8'd11) begin
            failures++;
            $display("FAIL scale2_done: done=%b valid=%b addr=%0d, expected 1 0 11",
                     bus_b.frame_done, bus_b.addr_valid, bus_b.address);
        end
        bus_b.vsync  = 1'b0;
        bus_b.enable = 1'b0;
        step();
    endtask

    task automatic test_vsync_abort();
        bus_a.vsync  = 1'b1;
        bus_a.enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (bus_a.address !== 8'd5) begin
            failures++;
            $display("FAIL abort_pre: addr=%0d expected 5", bus_a.address);
        end
        bus_a.vsync = 1'b0;
        step();
        checks++;
        if (bus_a.address !== 8'd0 || bus_a.addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_sync: addr=%0d valid=%b, expected 0 0", bus_a.address, bus_a.addr_valid);
        end
        bus_a.vsync = 1'b1;
        step();
        checks++;
        if (bus_a.address !== 8'd0 || bus_a.addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart: addr=%0d valid=%b, expected 0 1", bus_a.address, bus_a.addr_valid);
        end
        step();
        checks++;
        if (bus_a.address !== 8'd1 || bus_a.addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_next: addr=%0d valid=%b, expected 1 1", bus_a.address, bus_a.addr_valid);
        end
    endtask

    task automatic test_enable_toggle();
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int exp_addr;
        bus_a.vsync  = 1'b0;
        bus_a.enable = 1'b0;
        step();
        bus_a.vsync = 1'b1;
        step();
        exp_addr = 0;
        for (int i = 0; i < 7; i++) begin
            bus_a.enable = pat[i];
            step();
            if (pat[i]) exp_addr++;
            checks++;
            if (bus_a.address !== 8'(exp_addr) || bus_a.addr_valid !== 1'b1) begin
                failures++;
                $display("FAIL enable_toggle[%0d]: addr=%0d valid=%b, expected %0d 1",
                         i, bus_a.address, bus_a.addr_valid, exp_addr);
            end
        end
    endtask

    task automatic test_swap();
        bus_a.enable   = 1'b1;
        bus_a.swap_req = 1'b1;
        step();
        bus_a.swap_req = 1'b0;
        checks++;
        if (bus_a.bank_sel !== 1'b0) begin
            failures++;
            $display("FAIL swap_early: bank=%b expected 0", bus_a.bank_sel);
        end
        step();
        bus_a.vsync = 1'b0;
        step();
        checks++;
        if (bus_a.bank_sel !== 1'b1 || bus_a.address !== 8'd12 || bus_a.addr_valid !== 1'b0) begin
            failures++;
            $display("FAIL swap_apply: bank=%b addr=%0d valid=%b, expected 1 12 0",
                     bus_a.bank_sel, bus_a.address, bus_a.addr_valid);
        end
        bus_a.vsync = 1'b1;
        step();
        step();
        checks++;
        if (bus_a.address !== 8'd13 || bus_a.addr_valid !== 1'b1) begin
            failures++;
            $display("FAIL swap_scan: addr=%0d valid=%b, expected 13 1", bus_a.address, bus_a.addr_valid);
        end
        bus_a.vsync = 1'b0;
        step();
        checks++;
        if (bus_a.bank_sel !== 1'b1 || bus_a.address !== 8'd12) begin
            failures++;
            $display("FAIL swap_persist: bank=%b addr=%0d, expected 1 12", bus_a.bank_sel, bus_a.address);
        end
        bus_a.vsync = 1'b1;
        step();
    endtask

    task automatic test_swap_same_cycle();
        bus_a.vsync    = 1'b0;
        bus_a.swap_req = 1'b1;
        step();
        bus_a.swap_req = 1'b0;
        checks++;
        if (bus_a.bank_sel !== 1'b1 || bus_a.address !== 8'd12) begin
            failures++;
            $display("FAIL swap_same_edge: bank=%b addr=%0d, expected 1 12", bus_a.bank_sel, bus_a.address);
        end
        bus_a.vsync = 1'b1;
        step();
        bus_a.vsync = 1'b0;
        step();
        checks++;
        if (bus_a.bank_sel !== 1'b0 || bus_a.address !== 8'd0) begin
            failures++;
            $display("FAIL swap_latched: bank=%b addr=%0d, expected 0 0", bus_a.bank_sel, bus_a.address);
        end
    endtask

    task automatic test_single_bank();
        bus_b.vsync = 1'b1;
        step();
        bus_b.swap_req = 1'b1;
        step();
        bus_b.swap_req = 1'b0;
        bus_b.vsync    = 1'b0;
        step();
        checks++;
        if (bus_b.bank_sel !== 1'b0 || bus_b.address !== 8'd0) begin
            failures++;
            $display("FAIL single_bank: bank=%b addr=%0d, expected 0 0", bus_b.bank_sel, bus_b.address);
        end
    endtask

    task automatic test_reset_mid_frame();
        bus_a.swap_req = 1'b1;
        step();
        bus_a.swap_req = 1'b0;
        bus_a.vsync    = 1'b1;
        step();
        bus_a.vsync = 1'b0;
        step();
        bus_a.vsync  = 1'b1;
        bus_a.enable = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (bus_a.address !== 8'd19 || bus_a.bank_sel !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: addr=%0d bank=%b, expected 19 1", bus_a.address, bus_a.bank_sel);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_a.address !== 8'd0 || bus_a.bank_sel !== 1'b0 ||
            bus_a.addr_valid !== 1'b0 || bus_a.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: addr=%0d bank=%b valid=%b done=%b, expected 0 0 0 0",
                     bus_a.address, bus_a.bank_sel, bus_a.addr_valid, bus_a.frame_done);
        end
        step();
        rst = 1'b1;
        step();
        checks++;
        if (bus_a.address !== 8'd0 || bus_a.addr_valid !== 1'b1 || bus_a.bank_sel !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart: addr=%0d valid=%b bank=%b, expected 0 1 0",
                     bus_a.address, bus_a.addr_valid, bus_a.bank_sel);
        end
        step();
        checks++;
        if (bus_a.address !== 8'd1) begin
            failures++;
            $display("FAIL rst_next: addr=%0d expected 1", bus_a.address);
        end
    endtask

    initial begin
        bus_a.enable = 1'b0; bus_a.vsync = 1'b0; bus_a.swap_req = 1'b0;
        bus_b.enable = 1'b0; bus_b.vsync = 1'b0; bus_b.swap_req = 1'b0;
        test_reset();
        test_linear();
        test_scale2();
        test_vsync_abort();
        test_enable_toggle();
        test_swap();
        test_swap_same_cycle();
        test_single_bank();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
